// File: rtl/acc_divider.sv
// -----------------------------------------------------------------------------
// acc_divider
//   Unsigned 32/16 restoring divider, intended for turning an accumulated sum
//   into a mean (dividend = accumulator, divisor = sample count). One quotient
//   bit is produced per clock, MSB first, so a normal division finishes 32
//   clocks after the start is accepted. A zero divisor finishes at once with
//   quotient = all ones and div_zero flagged.
//
// Ports
//   clk_i        : clock, all state changes on the rising edge
//   rst_ni       : asynchronous active-low reset
//   start_i      : request pulse, only looked at while idle
//   dividend_i   : 32-bit unsigned dividend, latched on accepted start
//   divisor_i    : 16-bit unsigned divisor, latched on accepted start
//   quotient_o   : registered quotient, held until the next result
//   remainder_o  : registered remainder (0 when the remainder is not built)
//   busy_o       : high while the iterations are running
//   done_o       : one-cycle pulse when results become valid
//   div_zero_o   : divide-by-zero flag, held until the next accepted start
//
// Build option
//   ACC_DIVIDER_REMAINDER_EN : when defined the true remainder is registered and
//   output; when undefined remainder_o is tied to 0 and its register removed.
// -----------------------------------------------------------------------------
module acc_divider (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] dividend_i,
    input  logic [15:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [15:0] remainder_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        div_zero_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // shift_q starts out holding the dividend; each iteration moves its MSB
    // into the partial remainder and shifts the new quotient bit in at the
    // bottom, so after 32 iterations it holds the whole quotient.
    logic [31:0] shift_q;
    logic [15:0] divisor_q;
    logic [16:0] prem_q;
    logic [4:0]  cnt_q;
    logic [31:0] quotient_q;
    logic        div_zero_q;

    logic [16:0] trial;
    logic [16:0] diff;
    logic        qbit;
    logic [16:0] prem_next;
    logic        last_iter;

    // The partial remainder is always below the divisor after an iteration,
    // so its top bit never feeds the next shift.
    logic        unused_prem_msb;
    assign unused_prem_msb = prem_q[16];

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    always_comb begin
        trial     = {prem_q[15:0], shift_q[31]};
        diff      = trial - {1'b0, divisor_q};
        qbit      = (trial >= {1'b0, divisor_q});
        prem_next = qbit ? diff : trial;
        last_iter = (cnt_q == 5'd31);
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (divisor_i == 16'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q    <= '0;
            divisor_q  <= '0;
            prem_q     <= '0;
            cnt_q      <= '0;
            quotient_q <= '0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        shift_q    <= dividend_i;
                        divisor_q  <= divisor_i;
                        prem_q     <= '0;
                        cnt_q      <= '0;
                        div_zero_q <= (divisor_i == 16'd0);
                        if (divisor_i == 16'd0) begin
                            quotient_q <= 32'hFFFF_FFFF;
                        end
                    end
                end
                S_RUN: begin
                    shift_q <= {shift_q[30:0], qbit};
                    prem_q  <= prem_next;
                    cnt_q   <= cnt_q + 5'd1;
                    if (last_iter) begin
                        quotient_q <= {shift_q[30:0], qbit};
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ACC_DIVIDER_REMAINDER_EN
    logic [15:0] remainder_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            remainder_q <= '0;
        end else if (state_q == S_IDLE && start_i && divisor_i == 16'd0) begin
            remainder_q <= '0;
        end else if (state_q == S_RUN && last_iter) begin
            remainder_q <= prem_next[15:0];
        end
    end

    assign remainder_o = remainder_q;
`else
    assign remainder_o = 16'd0;
`endif

    // ---------------- outputs ----------------
    always_comb begin
        busy_o     = (state_q == S_RUN);
        done_o     = (state_q == S_DONE);
        quotient_o = quotient_q;
        div_zero_o = div_zero_q;
    end

endmodule

// File: tb/tb_acc_divider.sv
// -----------------------------------------------------------------------------
// tb_acc_divider
//   Self-checking bench for acc_divider: directed cases plus random operands,
//   compared against plain integer division. Honours ACC_DIVIDER_REMAINDER_EN
//   the same way the design does.
// -----------------------------------------------------------------------------
module tb_acc_divider;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [31:0] dividend_i;
    logic [15:0] divisor_i;
    logic [31:0] quotient_o;
    logic [15:0] remainder_o;
    logic        busy_o;
    logic        done_o;
    logic        div_zero_o;

    int n_checks = 0;
    int n_fail   = 0;

    acc_divider dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .div_zero_o  (div_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    function automatic logic [31:0] ref_quot(input logic [31:0] a, input logic [15:0] b);
        if (b == 16'd0) return 32'hFFFF_FFFF;
        return a / {16'd0, b};
    endfunction

    function automatic logic [15:0] ref_rem(input logic [31:0] a, input logic [15:0] b);
        logic [31:0] r;
        if (b == 16'd0) return 16'd0;
`ifdef ACC_DIVIDER_REMAINDER_EN
        r = a % {16'd0, b};
`else
        r = 32'd0;
`endif
        return r[15:0];
    endfunction

    // Runs one division; optionally disturbs start/operands at RUN cycle 10.
    task automatic do_div(input logic [31:0] a, input logic [15:0] b, input bit disturb);
        int          lat;
        logic [31:0] eq;
        logic [15:0] er;
        eq = ref_quot(a, b);
        er = ref_rem(a, b);
        @(negedge clk_i);
        start_i    = 1'b1;
        dividend_i = a;
        divisor_i  = b;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        check("busy_after_accept", {31'd0, busy_o}, {31'd0, (b != 16'd0)});
        check("div_zero_at_accept", {31'd0, div_zero_o}, {31'd0, (b == 16'd0)});
        lat = 0;
        while (!done_o && lat < 40) begin
            if (disturb && lat == 10) begin
                start_i    = 1'b1;
                dividend_i = $urandom;
                divisor_i  = 16'($urandom_range(1, 65535));
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk_i); #1;
            lat++;
            if (busy_o && done_o) check("busy_done_overlap", 32'd1, 32'd0);
        end
        start_i = 1'b0;
        check("latency", lat, (b == 16'd0) ? 32'd0 : 32'd32);
        check("done", {31'd0, done_o}, 32'd1);
        check("busy_at_done", {31'd0, busy_o}, 32'd0);
        check("quotient", quotient_o, eq);
        check("remainder", {16'd0, remainder_o}, {16'd0, er});
        check("div_zero", {31'd0, div_zero_o}, {31'd0, (b == 16'd0)});
        $display("div %0d / %0d -> q=%0d r=%0d dz=%0b latency=%0d", a, b, quotient_o, remainder_o, div_zero_o, lat);
        @(posedge clk_i); #1;
        check("done_pulse_end", {31'd0, done_o}, 32'd0);
        check("quotient_hold", quotient_o, eq);
        check("div_zero_hold", {31'd0, div_zero_o}, {31'd0, (b == 16'd0)});
    endtask

    initial begin
        logic [31:0] ra;
        logic [15:0] rb;
        rst_ni     = 1'b0;
        start_i    = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        #1;
        check("rst_quotient", quotient_o, 32'd0);
        check("rst_remainder", {16'd0, remainder_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_div_zero", {31'd0, div_zero_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        do_div(32'd1000, 16'd7, 1'b0);
        do_div(32'd3005, 16'd13, 1'b0);
        do_div(32'hFFFF_FFFF, 16'd1, 1'b0);
        do_div(32'd5, 16'd9, 1'b0);
        do_div(32'd100, 16'd0, 1'b0);
        do_div(32'd1000, 16'd7, 1'b1);
        do_div(32'hFFFF_FFFF, 16'hFFFF, 1'b0);
        do_div(32'd0, 16'd3, 1'b0);

        // Reset in the middle of RUN: outputs drop at once, no done follows.
        @(negedge clk_i);
        start_i    = 1'b1;
        dividend_i = 32'd1000;
        divisor_i  = 16'd7;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (15) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrun_rst_quotient", quotient_o, 32'd0);
        check("midrun_rst_remainder", {16'd0, remainder_o}, 32'd0);
        check("midrun_rst_busy", {31'd0, busy_o}, 32'd0);
        check("midrun_rst_done", {31'd0, done_o}, 32'd0);
        check("midrun_rst_div_zero", {31'd0, div_zero_o}, 32'd0);
        $display("reset asserted mid-run: busy=%0b done=%0b", busy_o, done_o);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk_i); #1;
            if (done_o || busy_o) check("no_activity_after_abort", 32'd1, 32'd0);
        end
        do_div(32'd1000, 16'd7, 1'b0);

        // Random operands, with small and zero divisors mixed in.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 16'd0;
                1:       rb = 16'($urandom_range(1, 15));
                default: rb = 16'($urandom);
            endcase
            if ($urandom_range(0, 4) == 0) ra = 32'($urandom_range(0, 65535));
            do_div(ra, rb, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net against a hang.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
